// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_pkg                                                        |
// | Load/store opcodes, bus size encodings and FSM states for the MEM stage.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

  localparam logic [7:0] c_OP_LB  = 8'h20;
  localparam logic [7:0] c_OP_LBU = 8'h21;
  localparam logic [7:0] c_OP_LH  = 8'h22;
  localparam logic [7:0] c_OP_LHU = 8'h23;
  localparam logic [7:0] c_OP_LW  = 8'h24;
  localparam logic [7:0] c_OP_SB  = 8'h28;
  localparam logic [7:0] c_OP_SH  = 8'h29;
  localparam logic [7:0] c_OP_SW  = 8'h2A;

  localparam logic [1:0] c_SIZE_BYTE = 2'd0;
  localparam logic [1:0] c_SIZE_HALF = 2'd1;
  localparam logic [1:0] c_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_align                                                      |
// | Store lane replication/strobes, load lane select + extension, align check. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [1:0]  o_size,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign,
  output logic        o_is_load,
  output logic        o_is_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_size      = c_SIZE_WORD;
    o_wdata     = i_wdata;
    o_wstrb     = 4'b0000;
    o_rdata_ext = i_rdata;
    o_misalign  = 1'b0;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    case (i_op)
      c_OP_LB: begin
        o_is_load   = 1'b1;
        o_size      = c_SIZE_BYTE;
        o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      end
      c_OP_LBU: begin
        o_is_load   = 1'b1;
        o_size      = c_SIZE_BYTE;
        o_rdata_ext = {24'h0, w_byte};
      end
      c_OP_LH: begin
        o_is_load   = 1'b1;
        o_size      = c_SIZE_HALF;
        o_misalign  = i_addr_lo[0];
        o_rdata_ext = {{16{w_half[15]}}, w_half};
      end
      c_OP_LHU: begin
        o_is_load   = 1'b1;
        o_size      = c_SIZE_HALF;
        o_misalign  = i_addr_lo[0];
        o_rdata_ext = {16'h0, w_half};
      end
      c_OP_LW: begin
        o_is_load   = 1'b1;
        o_misalign  = |i_addr_lo;
      end
      c_OP_SB: begin
        o_is_store  = 1'b1;
        o_size      = c_SIZE_BYTE;
        o_wdata     = {4{i_wdata[7:0]}};
        o_wstrb     = 4'b0001 << i_addr_lo;
      end
      c_OP_SH: begin
        o_is_store  = 1'b1;
        o_size      = c_SIZE_HALF;
        o_misalign  = i_addr_lo[0];
        o_wdata     = {2{i_wdata[15:0]}};
        o_wstrb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      c_OP_SW: begin
        o_is_store  = 1'b1;
        o_misalign  = |i_addr_lo;
        o_wstrb     = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | MEM-stage load/store engine: one SRAM-style bus transaction per instr.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flushM,
  input  logic          memenM,
  input  logic          MemWriteM,
  input  logic [7:0]    ALUControlM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  output logic          stallM,
  output logic [31:0]   readdataM,
  output logic          adelM,
  output logic          adesM,
  output logic [31:0]   badaddrM,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  output logic [3:0]    data_wstrb,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  state_t        r_state;
  state_t        w_next;
  logic          r_killed;
  logic [31:0]   r_rdata;
  logic          r_req;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;

  logic [1:0]    w_size;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_rdata_ext;
  logic          w_misalign;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_active;
  logic          w_go;

  mem_access_unit_align u_align (
    .i_op        (ALUControlM),
    .i_addr_lo   (aluoutM[1:0]),
    .i_wdata     (writedataM),
    .i_rdata     (r_rdata),
    .o_size      (w_size),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store)
  );

  assign w_active  = memenM & ~flushM;
  assign adelM     = w_active & w_is_load & w_misalign;
  assign adesM     = w_active & w_is_store & w_misalign;
  assign badaddrM  = aluoutM;
  assign w_go      = w_active & ~adelM & ~adesM;
  assign readdataM = w_rdata_ext;

  always_comb begin
    w_next = r_state;
    stallM = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stallM = w_go;
        if (w_go) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        stallM = 1'b1;
        if (data_addr_ok) w_next = ST_DATA;
      end
      ST_DATA: begin
        stallM = 1'b1;
        // A flush arriving together with data_ok kills the result just like an earlier one.
        if (data_data_ok) w_next = (r_killed | flushM) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_killed <= 1'b0;
      r_rdata  <= '0;
      r_req    <= 1'b0;
      r_wr     <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_go) begin
        r_req   <= 1'b1;
        r_wr    <= MemWriteM;
        r_size  <= w_size;
        r_addr  <= aluoutM[AW-1:0];
        r_wdata <= w_wdata[DW-1:0];
        r_wstrb <= w_wstrb;
      end else if (r_state == ST_ADDR && data_addr_ok) begin
        r_req <= 1'b0;
      end
      if (r_state == ST_DATA && data_data_ok) begin
        r_rdata  <= data_rdata[31:0];
        r_killed <= 1'b0;
      end else if ((r_state == ST_ADDR || r_state == ST_DATA) && flushM) begin
        r_killed <= 1'b1;
      end
    end
  end

  assign data_req   = r_req;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign data_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Directed self-checking bench; bus slave responses driven per cycle.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flushM = 1'b0;
  logic        memenM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [7:0]  ALUControlM = 8'h0;
  logic [31:0] aluoutM = 32'h0;
  logic [31:0] writedataM = 32'h0;
  logic        stallM;
  logic [31:0] readdataM;
  logic        adelM, adesM;
  logic [31:0] badaddrM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .flushM(flushM), .memenM(memenM), .MemWriteM(MemWriteM),
    .ALUControlM(ALUControlM), .aluoutM(aluoutM), .writedataM(writedataM),
    .stallM(stallM), .readdataM(readdataM), .adelM(adelM), .adesM(adesM), .badaddrM(badaddrM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  // Issues one instruction and plays the slave: addr_ok after aw waits, data_ok dw cycles after that.
  task automatic run_txn(input logic [7:0] op, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int aw, input int dw, input logic [31:0] rd,
                         output int stalls, output logic [31:0] rdout, output logic done,
                         output logic c_wr, output logic [1:0] c_size, output logic [31:0] c_addr,
                         output logic [31:0] c_wdata, output logic [3:0] c_wstrb,
                         output logic stable);
    int  ca, cd;
    logic acc, seen;
    stalls = 0; rdout = 32'h0; done = 1'b0; stable = 1'b1; acc = 1'b0; seen = 1'b0;
    c_wr = 1'b0; c_size = 2'd0; c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0;
    ca = 0; cd = 0;
    @(negedge clk);
    memenM = 1'b1; MemWriteM = wr; ALUControlM = op; aluoutM = addr; writedataM = wd;
    data_rdata = rd; flushM = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      if (!stallM) begin
        done = 1'b1; rdout = readdataM;
        break;
      end
      stalls++;
      if (data_req) begin
        if (!seen) begin
          seen = 1'b1; c_wr = data_wr; c_size = data_size; c_addr = data_addr;
          c_wdata = data_wdata; c_wstrb = data_wstrb;
        end else if (c_wr !== data_wr || c_size !== data_size || c_addr !== data_addr ||
                     c_wdata !== data_wdata || c_wstrb !== data_wstrb) begin
          stable = 1'b0;
        end
        if (ca == aw) begin data_addr_ok = 1'b1; acc = 1'b1; end
        else ca++;
      end else if (acc) begin
        if (cd == dw) data_data_ok = 1'b1;
        else cd++;
      end
    end
    memenM = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (data_req !== 1'b0 || stallM !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: req=%b stall=%b required 0 0", data_req, stallM);
    end
    checks++;
    if (readdataM !== 32'h0 || data_addr !== 32'h0 || data_wdata !== 32'h0 ||
        data_wstrb !== 4'h0 || data_size !== 2'd0 || data_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rd=%h addr=%h wd=%h strb=%h size=%0d wr=%b required all 0",
               readdataM, data_addr, data_wdata, data_wstrb, data_size, data_wr);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw;
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    run_txn(c_OP_LW, 1'b0, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF, s, r, d, w, sz, ad, wdv, sb, st);
    checks++;
    if (!d || s != 3) begin errors++; $display("FAIL lw_stall: done=%b stalls=%0d required 1 3", d, s); end
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h required deadbeef", r); end
    checks++;
    if (w !== 1'b0 || sz !== 2'd2 || ad !== 32'h1000 || sb !== 4'h0) begin
      errors++; $display("FAIL lw_bus: wr=%b size=%0d addr=%h strb=%h required 0 2 1000 0", w, sz, ad, sb);
    end
    run_txn(c_OP_LW, 1'b0, 32'h1008, 32'h0, 0, 2, 32'h0BADF00D, s, r, d, w, sz, ad, wdv, sb, st);
    checks++;
    if (!d || s != 5 || r !== 32'h0BADF00D) begin
      errors++; $display("FAIL lw_data_wait: stalls=%0d data=%h required 5 0badf00d", s, r);
    end
  endtask

  task automatic test_load_ext;
    logic [7:0]  ops [5] = '{c_OP_LB, c_OP_LBU, c_OP_LH, c_OP_LHU, c_OP_LB};
    logic [31:0] adr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FF7F, 32'h0000007F};
    logic [1:0]  esz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    for (int i = 0; i < 5; i++) begin
      run_txn(ops[i], 1'b0, adr[i], 32'h0, 0, 0, 32'h80FFFF7F, s, r, d, w, sz, ad, wdv, sb, st);
      checks++;
      if (!d || r !== exp[i] || sz !== esz[i] || ad !== adr[i]) begin
        errors++;
        $display("FAIL load_ext[%0d]: done=%b data=%h size=%0d addr=%h required 1 %h %0d %h",
                 i, d, r, sz, ad, exp[i], esz[i], adr[i]);
      end
    end
  endtask

  task automatic test_store;
    logic [7:0]  ops [3] = '{c_OP_SH, c_OP_SB, c_OP_SW};
    logic [31:0] adr [3] = '{32'h2002, 32'h3001, 32'h2004};
    logic [31:0] wdi [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
    logic [31:0] ewd [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
    logic [3:0]  est [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [1:0]  esz [3] = '{2'd1, 2'd0, 2'd2};
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    for (int i = 0; i < 3; i++) begin
      run_txn(ops[i], 1'b1, adr[i], wdi[i], 0, 0, 32'h0, s, r, d, w, sz, ad, wdv, sb, st);
      checks++;
      if (!d || s != 3 || w !== 1'b1 || sz !== esz[i] || wdv !== ewd[i] || sb !== est[i]) begin
        errors++;
        $display("FAIL store[%0d]: stalls=%0d wr=%b size=%0d wdata=%h strb=%b required 3 1 %0d %h %b",
                 i, s, w, sz, wdv, sb, esz[i], ewd[i], est[i]);
      end
    end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    memenM = 1'b1; MemWriteM = 1'b0; ALUControlM = c_OP_LW; aluoutM = 32'h1001;
    #1;
    checks++;
    if (adelM !== 1'b1 || adesM !== 1'b0 || badaddrM !== 32'h1001 || stallM !== 1'b0 || data_req !== 1'b0) begin
      errors++;
      $display("FAIL adel: adel=%b ades=%b bad=%h stall=%b req=%b required 1 0 1001 0 0",
               adelM, adesM, badaddrM, stallM, data_req);
    end
    @(negedge clk); #1;
    checks++;
    if (data_req !== 1'b0) begin errors++; $display("FAIL adel_noreq: req=%b required 0", data_req); end
    MemWriteM = 1'b1; ALUControlM = c_OP_SW; aluoutM = 32'h1002;
    #1;
    checks++;
    if (adesM !== 1'b1 || adelM !== 1'b0 || badaddrM !== 32'h1002 || stallM !== 1'b0) begin
      errors++;
      $display("FAIL ades: ades=%b adel=%b bad=%h stall=%b required 1 0 1002 0", adesM, adelM, badaddrM, stallM);
    end
    @(negedge clk); #1;
    checks++;
    if (data_req !== 1'b0) begin errors++; $display("FAIL ades_noreq: req=%b required 0", data_req); end
    memenM = 1'b0;
  endtask

  task automatic test_addr_wait;
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    run_txn(c_OP_SW, 1'b1, 32'h4000, 32'hCAFEF00D, 4, 0, 32'h0, s, r, d, w, sz, ad, wdv, sb, st);
    checks++;
    if (!d || s != 7) begin errors++; $display("FAIL wait_stall: done=%b stalls=%0d required 1 7", d, s); end
    checks++;
    if (st !== 1'b1 || ad !== 32'h4000 || wdv !== 32'hCAFEF00D || sz !== 2'd2) begin
      errors++; $display("FAIL wait_stable: stable=%b addr=%h wdata=%h size=%0d required 1 4000 cafef00d 2",
                         st, ad, wdv, sz);
    end
  endtask

  task automatic test_flush;
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    @(negedge clk);
    memenM = 1'b1; MemWriteM = 1'b0; ALUControlM = c_OP_LW; aluoutM = 32'h1000;
    data_rdata = 32'h55555555;
    @(negedge clk); #1;
    checks++;
    if (data_req !== 1'b1) begin errors++; $display("FAIL flush_addr: req=%b required 1", data_req); end
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flushM = 1'b1; memenM = 1'b0;
    #1;
    checks++;
    if (stallM !== 1'b1 || data_req !== 1'b0) begin
      errors++; $display("FAIL flush_data: stall=%b req=%b required 1 0", stallM, data_req);
    end
    @(negedge clk); flushM = 1'b0; #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL flush_drain: stall=%b required 1", stallM); end
    data_data_ok = 1'b1;
    // The next instruction arrives straight away; a wrongly entered DONE would show stallM=0 here.
    run_txn(c_OP_LW, 1'b0, 32'h1004, 32'h0, 0, 0, 32'h11223344, s, r, d, w, sz, ad, wdv, sb, st);
    checks++;
    if (!d || s != 3 || r !== 32'h11223344) begin
      errors++; $display("FAIL flush_next: done=%b stalls=%0d data=%h required 1 3 11223344", d, s, r);
    end
  endtask

  task automatic test_reset_in_addr;
    int s; logic [31:0] r, ad, wdv; logic d, w, st; logic [1:0] sz; logic [3:0] sb;
    @(negedge clk);
    memenM = 1'b1; MemWriteM = 1'b1; ALUControlM = c_OP_SW; aluoutM = 32'h5000; writedataM = 32'h1;
    @(negedge clk); #1;
    checks++;
    if (data_req !== 1'b1) begin errors++; $display("FAIL rst_addr_pre: req=%b required 1", data_req); end
    reset = 1'b1; memenM = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (data_req !== 1'b0 || stallM !== 1'b0) begin
      errors++; $display("FAIL rst_addr: req=%b stall=%b required 0 0", data_req, stallM);
    end
    reset = 1'b0;
    run_txn(c_OP_LW, 1'b0, 32'h6000, 32'h0, 0, 0, 32'h0000CAFE, s, r, d, w, sz, ad, wdv, sb, st);
    checks++;
    if (!d || s != 3 || r !== 32'h0000CAFE) begin
      errors++; $display("FAIL rst_recover: done=%b stalls=%0d data=%h required 1 3 0000cafe", d, s, r);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_addr_wait();
    test_flush();
    test_reset_in_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
